// File: rtl/fifo_word_packer.sv
// Drains a 16-bit FIFO and packs consecutive word pairs into one 2*DATA_W output word (first word low).
// Flush releases a held odd word as a zero-extended partial word.
module fifo_word_packer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic                fifo_valid,
    input  logic [DATA_W-1:0]   fifo_dout,
    output logic                fifo_read,
    input  logic                flush,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_partial,
    output logic [CNT_W-1:0]    pair_count,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                pending_r;
    logic                pending_next_s;
    logic [DATA_W-1:0]   lo_reg_r;
    logic [DATA_W-1:0]   lo_next_s;
    logic                read_en_s;
    logic                out_valid_next_s;
    logic                out_partial_next_s;
    logic [2*DATA_W-1:0] out_data_next_s;
    logic [CNT_W-1:0]    pair_count_next_s;
    logic                proto_err_next_s;

    // Reads are never issued while reset is held, so nothing is left in flight.
    assign fifo_read = reset & read_en_s;

    // Next-state, read request and output-register updates.
    always_comb begin
        state_next_s       = state_r;
        lo_next_s          = lo_reg_r;
        read_en_s          = 1'b0;
        out_valid_next_s   = out_valid;
        out_partial_next_s = out_partial;
        out_data_next_s    = out_data;
        pair_count_next_s  = pair_count;
        case (state_r)
            S_LO: begin
                // Arriving lo data lets the hi read go out on the same cycle.
                read_en_s = !fifo_empty && (!pending_r || fifo_valid);
                if (fifo_valid && pending_r) begin
                    lo_next_s    = fifo_dout;
                    state_next_s = S_HI;
                end else begin
                    state_next_s = S_LO;
                end
            end
            S_HI: begin
                read_en_s = !fifo_empty && !pending_r;
                if (fifo_valid && pending_r) begin
                    out_data_next_s    = {fifo_dout, lo_reg_r};
                    out_partial_next_s = 1'b0;
                    out_valid_next_s   = 1'b1;
                    state_next_s       = S_OUT;
                end else if (flush && !pending_r) begin
                    out_data_next_s    = {{DATA_W{1'b0}}, lo_reg_r};
                    out_partial_next_s = 1'b1;
                    out_valid_next_s   = 1'b1;
                    state_next_s       = S_OUT;
                end else begin
                    state_next_s = S_HI;
                end
            end
            S_OUT: begin
                read_en_s = 1'b0;
                if (out_ready) begin
                    out_valid_next_s   = 1'b0;
                    out_partial_next_s = 1'b0;
                    pair_count_next_s  = pair_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_next_s       = S_LO;
                end else begin
                    state_next_s = S_OUT;
                end
            end
            default: begin
                read_en_s    = 1'b0;
                state_next_s = S_LO;
            end
        endcase
        if (fifo_read) begin
            pending_next_s = 1'b1;
        end else if (fifo_valid) begin
            pending_next_s = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
        proto_err_next_s = proto_err | (fifo_valid & ~pending_r);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_LO;
            pending_r   <= 1'b0;
            lo_reg_r    <= {DATA_W{1'b0}};
            out_valid   <= 1'b0;
            out_data    <= {(2*DATA_W){1'b0}};
            out_partial <= 1'b0;
            pair_count  <= {CNT_W{1'b0}};
            proto_err   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pending_r   <= pending_next_s;
            lo_reg_r    <= lo_next_s;
            out_valid   <= out_valid_next_s;
            out_data    <= out_data_next_s;
            out_partial <= out_partial_next_s;
            pair_count  <= pair_count_next_s;
            proto_err   <= proto_err_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural FIFO model, vector table and multi-cycle corner sequences.
module tb_fifo_word_packer;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic          fifo_valid;
    logic [DW-1:0] fifo_dout;
    logic          fifo_read;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [2*DW-1:0] out_data;
    logic          out_partial;
    logic [CW-1:0] pair_count;
    logic          proto_err;

    fifo_word_packer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
        .fifo_dout(fifo_dout), .fifo_read(fifo_read), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_partial(out_partial),
        .pair_count(pair_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] fq [$];
    logic [32:0] hs_q [$];
    logic        last_rd;
    logic        under_seen;
    int          rd_count;
    int          tests = 0;
    int          failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample DUT at negedge, FIFO model answers reads one cycle later.
    task automatic step();
        @(negedge clk);
        last_rd = fifo_read;
        if (fifo_read) rd_count++;
        if (fifo_read && fq.size() == 0) under_seen = 1'b1;
        if (out_valid && out_ready) hs_q.push_back({out_partial, out_data});
        @(posedge clk);
        #1;
        fifo_valid = last_rd;
        if (last_rd && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic wait_hs(input int n, input string name);
        int k;
        k = 0;
        while (hs_q.size() < n && k < 200) begin
            step();
            k++;
        end
        if (hs_q.size() < n) begin
            failed++;
            tests++;
            $display("FAIL %s timeout: got %0d handshakes expected %0d", name, hs_q.size(), n);
        end
    endtask

    task automatic pop_hs(input string name, input logic [32:0] exp);
        logic [32:0] v;
        v = 33'h0;
        if (hs_q.size() > 0) v = hs_q.pop_front();
        check(name, {31'd0, v}, {31'd0, exp});
    endtask

    initial begin
        vecs[0] = '{lo: 16'h0001, hi: 16'h0002, exp: 32'h0002_0001};
        vecs[1] = '{lo: 16'hffff, hi: 16'h0000, exp: 32'h0000_ffff};
        vecs[2] = '{lo: 16'h8000, hi: 16'h0001, exp: 32'h0001_8000};
        vecs[3] = '{lo: 16'habcd, hi: 16'h1234, exp: 32'h1234_abcd};

        reset = 1'b0; fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_dout = 16'h0;
        flush = 1'b0; out_ready = 1'b0; under_seen = 1'b0; rd_count = 0; last_rd = 1'b0;
        push(16'h0fff);
        step(); step();
        check("rst_read", {63'd0, last_rd}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_partial", {63'd0, out_partial}, 64'd0);
        check("rst_count", {60'd0, pair_count}, 64'd0);
        check("rst_proto", {63'd0, proto_err}, 64'd0);
        fq.delete(); fifo_empty = 1'b1;
        reset = 1'b1;

        // Single pair from idle FIFO.
        out_ready = 1'b1; rd_count = 0; hs_q.delete();
        push(16'h0001); push(16'h0002);
        wait_hs(1, "t1");
        repeat (5) step();
        check("t1_hs_count", 64'(hs_q.size()), 64'd1);
        pop_hs("t1_data", {1'b0, 32'h0002_0001});
        check("t1_count", {60'd0, pair_count}, 64'd1);
        check("t1_reads", 64'(rd_count), 64'd2);

        // Eight words back-to-back.
        under_seen = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(i));
        wait_hs(4, "t2");
        repeat (3) step();
        pop_hs("t2_p0", {1'b0, 32'h0002_0001});
        pop_hs("t2_p1", {1'b0, 32'h0004_0003});
        pop_hs("t2_p2", {1'b0, 32'h0006_0005});
        pop_hs("t2_p3", {1'b0, 32'h0008_0007});
        check("t2_count", {60'd0, pair_count}, 64'd5);
        check("t2_empty", {63'd0, fifo_empty}, 64'd1);
        check("t2_under", {63'd0, under_seen}, 64'd0);

        // Vector table.
        for (int i = 0; i < 4; i++) begin
            push(vecs[i].lo); push(vecs[i].hi);
            wait_hs(1, "vec");
            pop_hs($sformatf("vec%0d", i), {1'b0, vecs[i].exp});
        end
        step();
        check("vec_count", {60'd0, pair_count}, 64'd9);

        // Flush of odd word held under backpressure.
        out_ready = 1'b0;
        push(16'h000a);
        repeat (4) step();
        check("t3_no_out", {63'd0, out_valid}, 64'd0);
        flush = 1'b1; step(); flush = 1'b0;
        check("t3_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold", {30'd0, out_valid, out_partial, out_data}, {30'd0, 2'b11, 32'h0000_000a});
        end
        out_ready = 1'b1;
        wait_hs(1, "t3");
        pop_hs("t3_hs", {1'b1, 32'h0000_000a});
        check("t3_drop", {63'd0, out_valid}, 64'd0);
        check("t3_count", {60'd0, pair_count}, 64'd10);

        // Long stall while more data queues up.
        out_ready = 1'b0;
        push(16'h1111); push(16'h2222);
        repeat (6) step();
        check("t4_valid", {63'd0, out_valid}, 64'd1);
        push(16'h3333); push(16'h4444);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_stall", {31'd0, last_rd, out_data}, {31'd0, 1'b0, 32'h2222_1111});
        end
        out_ready = 1'b1;
        wait_hs(2, "t4");
        pop_hs("t4_p0", {1'b0, 32'h2222_1111});
        pop_hs("t4_p1", {1'b0, 32'h4444_3333});
        step();
        check("t4_count", {60'd0, pair_count}, 64'd12);

        // Reset while a lo word is held.
        push(16'h0055);
        repeat (4) step();
        reset = 1'b0; step(); reset = 1'b1;
        check("t5_valid", {63'd0, out_valid}, 64'd0);
        check("t5_count", {60'd0, pair_count}, 64'd0);
        push(16'h0066); push(16'h0077);
        wait_hs(1, "t5");
        pop_hs("t5_data", {1'b0, 32'h0077_0066});

        // Stray fifo_valid with no read outstanding.
        repeat (3) step();
        fifo_valid = 1'b1; fifo_dout = 16'hdead;
        step();
        check("t6_set", {63'd0, proto_err}, 64'd1);
        repeat (3) step();
        check("t6_sticky", {63'd0, proto_err}, 64'd1);
        check("t6_no_out", {63'd0, out_valid}, 64'd0);
        reset = 1'b0; step(); reset = 1'b1;
        check("t6_clear", {63'd0, proto_err}, 64'd0);

        // Counter wrap after 2^CW handshakes.
        hs_q.delete();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) push(16'(b * 8 + i));
            wait_hs(4 * (b + 1), "t7");
            step();
            if (b == 1) check("t7_mid", {60'd0, pair_count}, 64'd8);
        end
        check("t7_hs", 64'(hs_q.size()), 64'd16);
        check("t7_wrap", {60'd0, pair_count}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
